barrett_reduce_stage: RTL and testbench

// - Downstream companion of the constant-multiplier quotient estimator t = floor(a*20159 / 2^26), which approximates floor(a/3329).
// - Feeds each input coefficient a to the multiplier and aligns a with the returned t.
// - Computes r = a - t*Q, corrects it into [0,Q) and buffers results behind a valid/ready interface.
// - Sits in the Kyber polynomial datapath between the NTT butterfly outputs and coefficient storage.

---
 rtl/kyber_pkg.sv | 19 +
 rtl/barrett_out_fifo.sv | 81 ++++++++
 rtl/barrett_reduce_stage.sv | 129 ++++++++++++
 tb/tb_barrett_reduce_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared constants and helpers for the Kyber coefficient datapath.
package kyber_pkg;

  localparam int unsigned Q          = 3329;
  localparam int unsigned DW         = 16;
  localparam int unsigned MULT_LAT   = 2;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned CW         = 18;
  localparam int unsigned HALF_Q     = (Q - 1) / 2;

  localparam logic signed [CW-1:0] Q_S      = CW'(Q);
  localparam logic signed [CW-1:0] HALF_Q_S = CW'(HALF_Q);

  // t*Q with Q = 2^11 + 2^10 + 2^8 + 1, formed without a multiplier.
  function automatic logic signed [CW-1:0] mul_q(input logic signed [CW-1:0] t);
    return (t <<< 11) + (t <<< 10) + (t <<< 8) + t;
  endfunction

endpackage

// File: rtl/barrett_out_fifo.sv
// Synchronous show-ahead FIFO with registered head data, valid and occupancy count.
module barrett_out_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic             wr_fire_c, rd_fire_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rd_valid = valid_q;
  assign rd_data  = data_q;
  assign count    = count_q;

  // Next pointers, count and head; the head register keeps its value while empty.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_fire_c = wr_en && (count_q != CNT_W'(DEPTH));
    rd_fire_c = rd_en && (count_q != '0);
    if (wr_fire_c) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd_fire_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (wr_fire_c && !rd_fire_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_fire_c && rd_fire_c) begin
      count_d = count_q - CNT_W'(1);
    end
    valid_d = (count_d != '0);
    data_d  = valid_d ? mem_d[rd_ptr_d] : data_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/barrett_reduce_stage.sv
// Barrett reduction back end: aligns a with the external quotient estimate t,
// forms r = a - t*Q, corrects into range and buffers behind valid/ready.
// BARRETT_CENTERED_EN: when defined, results are centered in [-1664,1664].
module barrett_reduce_stage
  import kyber_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_coeff,
  output logic [DW-1:0] mult_din,
  input  logic [DW-1:0] mult_dout,
  output logic          mult_srst,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_coeff
);

  localparam int unsigned SC_W  = $clog2(MULT_LAT + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + MULT_LAT + 3);

  logic [SC_W-1:0]      srst_cnt_q, srst_cnt_d;
  logic                 srst_q, srst_d;
  logic                 dl_vld_q [MULT_LAT];
  logic                 dl_vld_d [MULT_LAT];
  logic [DW-1:0]        dl_dat_q [MULT_LAT];
  logic [DW-1:0]        dl_dat_d [MULT_LAT];
  logic                 s1_vld_q, s1_vld_d;
  logic signed [CW-1:0] s1_r_q, s1_r_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [DW-1:0]        s2_dat_q, s2_dat_d;
  logic signed [CW-1:0] a_ext_c, t_ext_c, r_c;
  logic                 accept_c;
  logic [OCC_W-1:0]     inflight_c;
  logic [CNT_W-1:0]     fifo_count;

  assign mult_din  = in_coeff;
  assign mult_srst = srst_q;
  assign accept_c  = in_valid && in_ready;

  // Hold the multiplier in reset for MULT_LAT cycles after rst_n releases.
  always_comb begin
    srst_cnt_d = srst_cnt_q;
    if (srst_cnt_q != SC_W'(MULT_LAT)) begin
      srst_cnt_d = srst_cnt_q + SC_W'(1);
    end
    srst_d = (srst_cnt_d != SC_W'(MULT_LAT));
  end

  // Delay line aligned to the multiplier, then S1 (a - t*Q) and S2 (range correction).
  always_comb begin
    dl_vld_d[0] = accept_c;
    dl_dat_d[0] = in_coeff;
    for (int i = 1; i < int'(MULT_LAT); i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_dat_d[i] = dl_dat_q[i-1];
    end
    a_ext_c  = CW'($signed(dl_dat_q[MULT_LAT-1]));
    t_ext_c  = CW'($signed(mult_dout));
    s1_vld_d = dl_vld_q[MULT_LAT-1];
    s1_r_d   = a_ext_c - mul_q(t_ext_c);

    r_c = s1_r_q;
    if (s1_r_q[CW-1]) begin
      r_c = s1_r_q + Q_S;
    end else if (s1_r_q >= Q_S) begin
      r_c = s1_r_q - Q_S;
    end
`ifdef BARRETT_CENTERED_EN
    if (r_c > HALF_Q_S) begin
      r_c = r_c - Q_S;
    end
`else
`endif
    s2_vld_d = s1_vld_q;
    s2_dat_d = r_c[DW-1:0];
  end

  // Credit check: everything in flight plus buffered must fit in the FIFO.
  always_comb begin
    inflight_c = OCC_W'(s1_vld_q) + OCC_W'(s2_vld_q);
    for (int i = 0; i < int'(MULT_LAT); i++) begin
      inflight_c = inflight_c + OCC_W'(dl_vld_q[i]);
    end
    in_ready = !srst_q && ((OCC_W'(fifo_count) + inflight_c) < OCC_W'(FIFO_DEPTH));
  end

  // Pipeline and sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srst_cnt_q <= '0;
      srst_q     <= 1'b1;
      for (int i = 0; i < int'(MULT_LAT); i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_dat_q[i] <= '0;
      end
      s1_vld_q <= 1'b0;
      s1_r_q   <= '0;
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
    end else begin
      srst_cnt_q <= srst_cnt_d;
      srst_q     <= srst_d;
      dl_vld_q   <= dl_vld_d;
      dl_dat_q   <= dl_dat_d;
      s1_vld_q   <= s1_vld_d;
      s1_r_q     <= s1_r_d;
      s2_vld_q   <= s2_vld_d;
      s2_dat_q   <= s2_dat_d;
    end
  end

  barrett_out_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (s2_vld_q),
    .wr_data  (s2_dat_q),
    .rd_en    (out_ready),
    .rd_valid (out_valid),
    .rd_data  (out_coeff),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_barrett_reduce_stage.sv
// Bench for barrett_reduce_stage with a behavioural quotient-estimator model.
module tb_barrett_reduce_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_coeff;
  logic [15:0] mult_din;
  logic [15:0] mult_dout;
  logic        mult_srst;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_coeff;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  barrett_reduce_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coeff  (in_coeff),
    .mult_din  (mult_din),
    .mult_dout (mult_dout),
    .mult_srst (mult_srst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coeff (out_coeff)
  );

  always #5 clk = ~clk;

  // Quotient estimate t = floor(a*20159 / 2^26), two-cycle latency.
  function automatic logic [15:0] est(input logic [15:0] a);
    longint p;
    p = longint'($signed(a)) * 64'sd20159;
    p = p >>> 26;
    return 16'(p);
  endfunction

  logic [15:0] m1, m2;
  always @(posedge clk) begin
    if (mult_srst) begin
      m1 <= '0;
      m2 <= '0;
    end else begin
      m1 <= est(mult_din);
      m2 <= m1;
    end
  end
  assign mult_dout = m2;

  // Reference result: mathematical a mod 3329 (optionally centered).
  function automatic logic [15:0] ref_mod(input logic [15:0] a);
    int v;
    v = int'($signed(a)) % 3329;
    if (v < 0) v += 3329;
`ifdef BARRETT_CENTERED_EN
    if (v > 1664) v -= 3329;
`endif
    return 16'(v);
  endfunction

  // One cycle: apply inputs at the falling edge, note what the next rising edge transfers.
  task automatic step(input bit iv, input logic [15:0] ic, input bit ordy,
                      output bit acc, output bit pop, output logic [15:0] pv);
    in_valid  = iv;
    in_coeff  = ic;
    out_ready = ordy;
    acc = iv && (in_ready === 1'b1);
    pop = ordy && (out_valid === 1'b1);
    pv  = out_coeff;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_coeff !== 16'd0) begin n_err++; $display("FAIL rst_out_coeff: got %0d want 0", out_coeff); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (mult_srst !== 1'b1) begin n_err++; $display("FAIL rst_mult_srst: got %b want 1", mult_srst); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (mult_srst !== 1'b1) begin n_err++; $display("FAIL rel1_mult_srst: got %b want 1", mult_srst); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rel1_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (mult_srst !== 1'b0) begin n_err++; $display("FAIL rel2_mult_srst: got %b want 0", mult_srst); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel2_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_boundary();
    logic [15:0] vals [7];
    logic [15:0] exps [7];
    bit acc, pop;
    logic [15:0] pv;
    int k;
    vals = '{16'h7FFF, 16'h8000, 16'd3328, 16'd3329, 16'hFFFF, 16'd1665, 16'd1664};
`ifdef BARRETT_CENTERED_EN
    exps = '{16'(-523), 16'd522, 16'hFFFF, 16'd0, 16'hFFFF, 16'(-1664), 16'd1664};
`else
    exps = '{16'd2806, 16'd522, 16'd3328, 16'd0, 16'd3328, 16'd1665, 16'd1664};
`endif
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vals[i], 1'b1, acc, pop, pv);
      n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL bnd_accept[%0d]: got %b want 1", i, acc); end
      k = 1;
      pop = 1'b0;
      while (k < 20) begin
        step(1'b0, 16'd0, 1'b1, acc, pop, pv);
        if (pop) break;
        k++;
      end
      n_cmp++; if (k !== 5) begin n_err++; $display("FAIL bnd_latency[%0d]: got %0d want 5", i, k); end
      n_cmp++; if (pv !== exps[i]) begin n_err++; $display("FAIL bnd_value[%0d]: got %0d want %0d", i, $signed(pv), $signed(exps[i])); end
      repeat (2) step(1'b0, 16'd0, 1'b1, acc, pop, pv);
    end
  endtask

  task automatic test_backpressure();
    bit acc, pop;
    logic [15:0] pv, e;
    int idx, got, guard;
    exp_q.delete();
    idx = 0;
    repeat (30) begin
      step(1'b1, 16'(idx), 1'b0, acc, pop, pv);
      if (acc) begin exp_q.push_back(16'(idx)); idx++; end
    end
    n_cmp++; if (idx !== 8) begin n_err++; $display("FAIL bp_accepted: got %0d want 8", idx); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    got = 0;
    guard = 0;
    while (got < 20 && guard < 200) begin
      step(idx < 20, 16'(idx), 1'b1, acc, pop, pv);
      if (acc) begin exp_q.push_back(16'(idx)); idx++; end
      if (pop) begin
        e = (exp_q.size() > 0) ? ref_mod(exp_q.pop_front()) : 16'hDEAD;
        n_cmp++; if (pv !== e) begin n_err++; $display("FAIL bp_drain[%0d]: got %0d want %0d", got, pv, e); end
        got++;
      end
      guard++;
    end
    n_cmp++; if (got !== 20) begin n_err++; $display("FAIL bp_count: got %0d want 20", got); end
    step(1'b0, 16'd0, 1'b1, acc, pop, pv);
  endtask

  task automatic test_throughput();
    bit acc, pop, iv;
    logic [15:0] pv, e, v;
    int sent, got, cyc, last, gaps;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0; last = 0; gaps = 0;
    while (got < 100 && cyc < 300) begin
      iv = (sent < 100);
      v  = 16'($urandom);
      step(iv, v, 1'b1, acc, pop, pv);
      if (iv) begin
        n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL tp_in_ready[%0d]: got %b want 1", sent, acc); end
      end
      if (acc) begin exp_q.push_back(v); sent++; end
      if (pop) begin
        e = (exp_q.size() > 0) ? ref_mod(exp_q.pop_front()) : 16'hDEAD;
        n_cmp++; if (pv !== e) begin n_err++; $display("FAIL tp_value[%0d]: got %0d want %0d", got, pv, e); end
        if (got > 0 && cyc != last + 1) gaps++;
        last = cyc;
        got++;
      end
      cyc++;
    end
    n_cmp++; if (got !== 100) begin n_err++; $display("FAIL tp_count: got %0d want 100", got); end
    n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL tp_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_random();
    bit acc, pop, iv, rdy;
    logic [15:0] pv, e, v;
    int sent, got, cyc;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0;
    while (cyc < 600 && (cyc < 400 || got < sent)) begin
      iv  = (cyc < 400) && ($urandom_range(0, 3) != 0);
      rdy = (cyc >= 400) || ($urandom_range(0, 9) < 6);
      v   = 16'($urandom);
      step(iv, v, rdy, acc, pop, pv);
      if (acc) begin exp_q.push_back(v); sent++; end
      if (pop) begin
        e = (exp_q.size() > 0) ? ref_mod(exp_q.pop_front()) : 16'hDEAD;
        n_cmp++; if (pv !== e) begin n_err++; $display("FAIL rnd_value[%0d]: got %0d want %0d", got, pv, e); end
        got++;
      end
      cyc++;
    end
    n_cmp++; if (got !== sent || sent == 0) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", got, sent); end
  endtask

  task automatic test_reset_mid();
    bit acc, pop;
    logic [15:0] pv, e, v;
    int got, guard, sent;
    exp_q.delete();
    repeat (5) step(1'b1, 16'($urandom), 1'b1, acc, pop, pv);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (mult_srst !== 1'b1) begin n_err++; $display("FAIL mid_mult_srst: got %b want 1", mult_srst); end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got = 0; guard = 0; sent = 0;
    while (in_ready !== 1'b1 && guard < 10) begin
      step(1'b0, 16'd0, 1'b1, acc, pop, pv);
      if (pop) got++;
      guard++;
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_timeout: got %b want 1", in_ready); end
    guard = 0;
    while (guard < 40) begin
      v = 16'($urandom);
      step(sent < 3, v, 1'b1, acc, pop, pv);
      if (acc) begin exp_q.push_back(v); sent++; end
      if (pop) begin
        e = (exp_q.size() > 0) ? ref_mod(exp_q.pop_front()) : 16'hDEAD;
        n_cmp++; if (pv !== e) begin n_err++; $display("FAIL mid_value[%0d]: got %0d want %0d", got, pv, e); end
        got++;
      end
      guard++;
    end
    n_cmp++; if (got !== 3) begin n_err++; $display("FAIL mid_count: got %0d want 3", got); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_coeff  = 16'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_boundary();
    test_backpressure();
    test_throughput();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
